// File: rtl/mem_stage_pkg.sv
// Shared rv32i mem-stage definitions: instruction type and subtype codes, FSM states, misalign helper.
// The helper is only referenced when MEM_MISALIGN_CHECK_EN is defined.
package mem_stage_pkg;

    localparam logic [3:0] AR_TYPE = 4'd1;
    localparam logic [3:0] L_TYPE  = 4'd2;
    localparam logic [3:0] S_TYPE  = 4'd3;
    localparam logic [3:0] DB_TYPE = 4'd4;
    localparam logic [3:0] IB_TYPE = 4'd5;

    // Load/store subtypes follow funct3, so S_SB/S_SH/S_SW share encodings with L_LB/L_LH/L_LW.
    localparam logic [3:0] L_LB  = 4'd0;
    localparam logic [3:0] L_LH  = 4'd1;
    localparam logic [3:0] L_LW  = 4'd2;
    localparam logic [3:0] L_LBU = 4'd4;
    localparam logic [3:0] L_LHU = 4'd5;
    localparam logic [3:0] S_SB  = 4'd0;
    localparam logic [3:0] S_SH  = 4'd1;
    localparam logic [3:0] S_SW  = 4'd2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2
    } mem_state_e;

    function automatic logic isMisaligned(input logic [3:0] subType, input logic [1:0] addrLo);
        case (subType)
            L_LH, L_LHU: return addrLo[0];
            L_LW:        return addrLo != 2'b00;
            default:     return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Combinational lane logic: store byte enables and lane replication, load lane extraction and extension.
module mem_lane_align
    import mem_stage_pkg::*;
(
    input  logic [3:0]  sub_type_i,
    input  logic [1:0]  addr_lo_i,
    input  logic [31:0] store_val_i,
    input  logic [31:0] rdata_i,
    output logic [3:0]  be_o,
    output logic [31:0] wdata_o,
    output logic [31:0] load_val_o
);

    logic [7:0]  laneByte;
    logic [15:0] laneHalf;

    // Byte enables depend only on access size, so loads reuse the store encoding.
    always_comb begin
        be_o    = 4'b1111;
        wdata_o = store_val_i;
        case (sub_type_i)
            S_SB, L_LBU: begin
                be_o    = 4'b0001 << addr_lo_i;
                wdata_o = {4{store_val_i[7:0]}};
            end
            S_SH, L_LHU: begin
                be_o    = addr_lo_i[1] ? 4'b1100 : 4'b0011;
                wdata_o = {2{store_val_i[15:0]}};
            end
            default: ;
        endcase
    end

    always_comb begin
        laneByte   = 8'(rdata_i >> {addr_lo_i, 3'b000});
        laneHalf   = addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];
        load_val_o = rdata_i;
        case (sub_type_i)
            L_LB:    load_val_o = {{24{laneByte[7]}}, laneByte};
            L_LBU:   load_val_o = {24'd0, laneByte};
            L_LH:    load_val_o = {{16{laneHalf[15]}}, laneHalf};
            L_LHU:   load_val_o = {16'd0, laneHalf};
            default: load_val_o = rdata_i;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// rv32i memory stage: handshaked loads/stores, pass-through of ALU results, write-back and bypass.
// Optional MEM_MISALIGN_CHECK_EN rejects misaligned halfword/word accesses with a mem_err pulse.
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int unsigned DMEM_TIMEOUT = 0
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        in_valid_i,
    input  logic [3:0]  insn_type_i,
    input  logic [3:0]  insn_sub_type_i,
    input  logic [31:0] alu_res_i,
    input  logic [31:0] store_val_i,
    input  logic [4:0]  rd_in_i,
    output logic        mem_stall_o,
    output logic        dmem_req_o,
    output logic        dmem_we_o,
    output logic [31:0] dmem_addr_o,
    output logic [3:0]  dmem_be_o,
    output logic [31:0] dmem_wdata_o,
    input  logic        dmem_ready_i,
    input  logic        dmem_rvalid_i,
    input  logic [31:0] dmem_rdata_i,
    output logic [4:0]  bp_mem_reg_o,
    output logic [31:0] bp_mem_val_o,
    output logic        wb_we_o,
    output logic [4:0]  wb_rd_o,
    output logic [31:0] wb_val_o,
    output logic        mem_err_o
);

    localparam logic [31:0] TimeoutLimit = 32'(DMEM_TIMEOUT);

    mem_state_e  state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [3:0]  subType_q, subType_d;
    logic [4:0]  rd_q, rd_d;
    logic [31:0] storeVal_q, storeVal_d;
    logic        isStore_q, isStore_d;
    logic [31:0] wait_q, wait_d;
    logic        wbWe_q, wbWe_d;
    logic [4:0]  wbRd_q, wbRd_d;
    logic [31:0] wbVal_q, wbVal_d;
    logic        memErr_q, memErr_d;

    logic        isMemOp;
    logic        isPassThrough;
    logic        misalignErr;
    logic        timeoutHit;
    logic        reqActive;
    logic [3:0]  laneBe;
    logic [31:0] laneWdata;
    logic [31:0] loadVal;

    mem_lane_align u_align (
        .sub_type_i  (subType_q),
        .addr_lo_i   (addr_q[1:0]),
        .store_val_i (storeVal_q),
        .rdata_i     (dmem_rdata_i),
        .be_o        (laneBe),
        .wdata_o     (laneWdata),
        .load_val_o  (loadVal)
    );

    assign isMemOp       = (insn_type_i == L_TYPE) || (insn_type_i == S_TYPE);
    assign isPassThrough = (insn_type_i == AR_TYPE) || (insn_type_i == DB_TYPE) ||
                           (insn_type_i == IB_TYPE);

`ifdef MEM_MISALIGN_CHECK_EN
    assign misalignErr = isMemOp && isMisaligned(insn_sub_type_i, alu_res_i[1:0]);
`else
    assign misalignErr = 1'b0;
`endif

    // Abort on the edge that closes the DMEM_TIMEOUT-th consecutive wait cycle of a phase.
    assign timeoutHit = (TimeoutLimit != 32'd0) && (wait_q == TimeoutLimit - 32'd1);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            addr_q     <= 32'd0;
            subType_q  <= 4'd0;
            rd_q       <= 5'd0;
            storeVal_q <= 32'd0;
            isStore_q  <= 1'b0;
            wait_q     <= 32'd0;
            wbWe_q     <= 1'b0;
            wbRd_q     <= 5'd0;
            wbVal_q    <= 32'd0;
            memErr_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            subType_q  <= subType_d;
            rd_q       <= rd_d;
            storeVal_q <= storeVal_d;
            isStore_q  <= isStore_d;
            wait_q     <= wait_d;
            wbWe_q     <= wbWe_d;
            wbRd_q     <= wbRd_d;
            wbVal_q    <= wbVal_d;
            memErr_q   <= memErr_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        subType_d  = subType_q;
        rd_d       = rd_q;
        storeVal_d = storeVal_q;
        isStore_d  = isStore_q;
        wait_d     = wait_q;
        wbWe_d     = 1'b0;
        wbRd_d     = wbRd_q;
        wbVal_d    = wbVal_q;
        memErr_d   = 1'b0;

        case (state_q)
            IDLE: begin
                if (in_valid_i) begin
                    if (misalignErr) begin
                        memErr_d = 1'b1;
                    end else if (isMemOp) begin
                        addr_d     = alu_res_i;
                        subType_d  = insn_sub_type_i;
                        rd_d       = rd_in_i;
                        storeVal_d = store_val_i;
                        isStore_d  = (insn_type_i == S_TYPE);
                        wait_d     = 32'd0;
                        state_d    = REQ;
                    end else if (isPassThrough) begin
                        wbWe_d  = (rd_in_i != 5'd0);
                        wbRd_d  = rd_in_i;
                        wbVal_d = alu_res_i;
                    end
                end
            end
            REQ: begin
                if (dmem_ready_i) begin
                    wait_d = 32'd0;
                    if (isStore_q) begin
                        state_d = IDLE;
                    end else if (dmem_rvalid_i) begin
                        wbWe_d  = (rd_q != 5'd0);
                        wbRd_d  = rd_q;
                        wbVal_d = loadVal;
                        state_d = IDLE;
                    end else begin
                        state_d = RESP;
                    end
                end else if (timeoutHit) begin
                    memErr_d = 1'b1;
                    wait_d   = 32'd0;
                    state_d  = IDLE;
                end else begin
                    wait_d = wait_q + 32'd1;
                end
            end
            RESP: begin
                if (dmem_rvalid_i) begin
                    wbWe_d  = (rd_q != 5'd0);
                    wbRd_d  = rd_q;
                    wbVal_d = loadVal;
                    wait_d  = 32'd0;
                    state_d = IDLE;
                end else if (timeoutHit) begin
                    memErr_d = 1'b1;
                    wait_d   = 32'd0;
                    state_d  = IDLE;
                end else begin
                    wait_d = wait_q + 32'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign reqActive    = (state_q == REQ);
    assign dmem_req_o   = reqActive;
    assign dmem_we_o    = reqActive & isStore_q;
    assign dmem_addr_o  = reqActive ? {addr_q[31:2], 2'b00} : 32'd0;
    assign dmem_be_o    = reqActive ? laneBe : 4'd0;
    assign dmem_wdata_o = (reqActive & isStore_q) ? laneWdata : 32'd0;

    assign mem_stall_o  = (state_q != IDLE) | (in_valid_i & isMemOp & (state_q == IDLE));

    assign wb_we_o      = wbWe_q;
    assign wb_rd_o      = wbRd_q;
    assign wb_val_o     = wbVal_q;
    assign bp_mem_reg_o = wbWe_q ? wbRd_q : 5'd0;
    assign bp_mem_val_o = wbWe_q ? wbVal_q : 32'd0;
    assign mem_err_o    = memErr_q;

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: directed vectors push expected events, a negedge monitor pops and compares.
// Honours MEM_MISALIGN_CHECK_EN the same way the design does.
module tb_mem_stage;
    import mem_stage_pkg::*;

    localparam int K_WB  = 0;
    localparam int K_REQ = 1;
    localparam int K_ERR = 2;

    typedef struct {
        int          kind;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] c;
        logic [31:0] d;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        inValid = 1'b0;
    logic [3:0]  insnType = 4'd0;
    logic [3:0]  insnSubType = 4'd0;
    logic [31:0] aluRes = 32'd0;
    logic [31:0] storeVal = 32'd0;
    logic [4:0]  rdIn = 5'd0;
    logic        dmemReady = 1'b0;
    logic        dmemRvalid = 1'b0;
    logic [31:0] dmemRdata = 32'd0;
    logic        memStall, dmemReq, dmemWe, wbWe, memErr;
    logic [31:0] dmemAddr, dmemWdata, bpVal, wbVal;
    logic [3:0]  dmemBe;
    logic [4:0]  bpReg, wbRd;

    mem_stage #(.DMEM_TIMEOUT(4)) dut (
        .clk_i           (clk),
        .rst_i           (rst),
        .in_valid_i      (inValid),
        .insn_type_i     (insnType),
        .insn_sub_type_i (insnSubType),
        .alu_res_i       (aluRes),
        .store_val_i     (storeVal),
        .rd_in_i         (rdIn),
        .mem_stall_o     (memStall),
        .dmem_req_o      (dmemReq),
        .dmem_we_o       (dmemWe),
        .dmem_addr_o     (dmemAddr),
        .dmem_be_o       (dmemBe),
        .dmem_wdata_o    (dmemWdata),
        .dmem_ready_i    (dmemReady),
        .dmem_rvalid_i   (dmemRvalid),
        .dmem_rdata_i    (dmemRdata),
        .bp_mem_reg_o    (bpReg),
        .bp_mem_val_o    (bpVal),
        .wb_we_o         (wbWe),
        .wb_rd_o         (wbRd),
        .wb_val_o        (wbVal),
        .mem_err_o       (memErr)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s got 0x%08h expected 0x%08h", name, actual, expected);
        end
    endtask

    task automatic expWb(input logic [4:0] rd, input logic [31:0] val);
        exp_t e;
        e.kind = K_WB; e.a = 32'(rd); e.b = val; e.c = 32'd0; e.d = 32'd0;
        sb.push_back(e);
    endtask

    task automatic expReq(input logic [31:0] addr, input logic [3:0] be, input logic we, input logic [31:0] wdata);
        exp_t e;
        e.kind = K_REQ; e.a = addr; e.b = 32'(be); e.c = 32'(we); e.d = wdata;
        sb.push_back(e);
    endtask

    task automatic expErr();
        exp_t e;
        e.kind = K_ERR; e.a = 32'd0; e.b = 32'd0; e.c = 32'd0; e.d = 32'd0;
        sb.push_back(e);
    endtask

    // Issues one instruction, plays the memory side with the given delays, returns at the result negedge.
    task automatic applyStimulus(input logic [3:0] t, input logic [3:0] sub, input logic [31:0] a,
                                 input logic [31:0] sv, input logic [4:0] rd, input int readyDelay,
                                 input int rvalidDelay, input logic [31:0] rdata);
        logic isMem;
        isMem = (t == L_TYPE) || (t == S_TYPE);
        @(posedge clk); #1;
        insnType = t; insnSubType = sub; aluRes = a; storeVal = sv; rdIn = rd; inValid = 1'b1;
        @(negedge clk);
        checkOutput("stallIssue", 32'(memStall), 32'(isMem));
        @(posedge clk); #1;
        inValid = 1'b0;
        if (isMem) begin
            for (int i = 0; i < readyDelay; i++) begin
                @(negedge clk);
                checkOutput("reqHeld", 32'(dmemReq), 32'd1);
                checkOutput("addrHeld", dmemAddr, {a[31:2], 2'b00});
                checkOutput("stallWait", 32'(memStall), 32'd1);
                @(posedge clk); #1;
            end
            dmemReady = 1'b1;
            if (t == L_TYPE && rvalidDelay == 0) begin
                dmemRvalid = 1'b1; dmemRdata = rdata;
            end
            @(posedge clk); #1;
            dmemReady = 1'b0; dmemRvalid = 1'b0;
            if (t == L_TYPE && rvalidDelay > 0) begin
                for (int i = 0; i < rvalidDelay - 1; i++) begin
                    @(posedge clk); #1;
                end
                dmemRvalid = 1'b1; dmemRdata = rdata;
                @(posedge clk); #1;
                dmemRvalid = 1'b0;
            end
        end
        @(negedge clk);
        if (t == S_TYPE) checkOutput("storeNoWb", 32'(wbWe), 32'd0);
    endtask

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (wbWe === 1'b1) begin
                if (sb.size() != 0 && sb[0].kind == K_WB) begin
                    e = sb.pop_front();
                    checkOutput("wbRd", 32'(wbRd), e.a);
                    checkOutput("wbVal", wbVal, e.b);
                    checkOutput("bpReg", 32'(bpReg), e.a);
                    checkOutput("bpVal", bpVal, e.b);
                end else begin
                    checks++; errors++;
                    $display("[TB] FAIL wbUnexpected got rd=%0d val=0x%08h expected no write-back", wbRd, wbVal);
                end
            end
            if (dmemReq === 1'b1 && dmemReady === 1'b1) begin
                if (sb.size() != 0 && sb[0].kind == K_REQ) begin
                    e = sb.pop_front();
                    checkOutput("reqAddr", dmemAddr, e.a);
                    checkOutput("reqBe", 32'(dmemBe), e.b);
                    checkOutput("reqWe", 32'(dmemWe), e.c);
                    if (e.c != 32'd0) checkOutput("reqWdata", dmemWdata, e.d);
                end else begin
                    checks++; errors++;
                    $display("[TB] FAIL reqUnexpected got addr=0x%08h expected no request", dmemAddr);
                end
            end
            if (memErr === 1'b1) begin
                if (sb.size() != 0 && sb[0].kind == K_ERR) begin
                    e = sb.pop_front();
                    checkOutput("errWbWe", 32'(wbWe), e.c);
                end else begin
                    checks++; errors++;
                    $display("[TB] FAIL errUnexpected got mem_err=1 expected 0");
                end
            end
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int reqCycles;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("rstStall", 32'(memStall), 32'd0);
        checkOutput("rstReq", 32'(dmemReq), 32'd0);
        checkOutput("rstAddr", dmemAddr, 32'd0);
        checkOutput("rstWbWe", 32'(wbWe), 32'd0);
        checkOutput("rstBpVal", bpVal, 32'd0);
        checkOutput("rstErr", 32'(memErr), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        expWb(5'd5, 32'h0000_1234);
        applyStimulus(AR_TYPE, 4'd0, 32'h0000_1234, 32'd0, 5'd5, 0, 0, 32'd0);

        expReq(32'h0000_0100, 4'b1000, 1'b1, 32'hABAB_ABAB);
        applyStimulus(S_TYPE, S_SB, 32'h0000_0103, 32'h1234_56AB, 5'd0, 2, 0, 32'd0);

        expReq(32'h0000_0100, 4'b0100, 1'b0, 32'd0);
        expWb(5'd7, 32'hFFFF_FF80);
        applyStimulus(L_TYPE, L_LB, 32'h0000_0102, 32'd0, 5'd7, 0, 0, 32'h0080_FF00);

        expReq(32'h0000_0100, 4'b0100, 1'b0, 32'd0);
        expWb(5'd8, 32'h0000_0080);
        applyStimulus(L_TYPE, L_LBU, 32'h0000_0102, 32'd0, 5'd8, 0, 1, 32'h0080_FF00);

        expReq(32'h0000_0100, 4'b1100, 1'b0, 32'd0);
        expWb(5'd9, 32'h0000_0080);
        applyStimulus(L_TYPE, L_LHU, 32'h0000_0102, 32'd0, 5'd9, 1, 2, 32'h0080_FF00);

        expReq(32'h0000_0100, 4'b0011, 1'b0, 32'd0);
        expWb(5'd12, 32'hFFFF_FF00);
        applyStimulus(L_TYPE, L_LH, 32'h0000_0100, 32'd0, 5'd12, 0, 0, 32'h0080_FF00);

        expReq(32'h0000_0104, 4'b1111, 1'b0, 32'd0);
        applyStimulus(L_TYPE, L_LW, 32'h0000_0104, 32'd0, 5'd0, 0, 1, 32'hDEAD_BEEF);
        checkOutput("rd0WbWe", 32'(wbWe), 32'd0);
        checkOutput("rd0BpVal", bpVal, 32'd0);

        expReq(32'h0000_0104, 4'b1100, 1'b1, 32'hBEEF_BEEF);
        applyStimulus(S_TYPE, S_SH, 32'h0000_0106, 32'hCAFE_BEEF, 5'd0, 0, 0, 32'd0);

        expReq(32'h0000_0200, 4'b1111, 1'b1, 32'h1122_3344);
        applyStimulus(S_TYPE, S_SW, 32'h0000_0200, 32'h1122_3344, 5'd0, 1, 0, 32'd0);

        applyStimulus(DB_TYPE, 4'd0, 32'h0000_0080, 32'd0, 5'd0, 0, 0, 32'd0);
        checkOutput("dbNoWb", 32'(wbWe), 32'd0);

        expWb(5'd3, 32'h0000_0400);
        applyStimulus(IB_TYPE, 4'd0, 32'h0000_0400, 32'd0, 5'd3, 0, 0, 32'd0);
        @(negedge clk);
        checkOutput("idleWbWe", 32'(wbWe), 32'd0);

`ifdef MEM_MISALIGN_CHECK_EN
        expErr();
        @(posedge clk); #1;
        insnType = L_TYPE; insnSubType = L_LW; aluRes = 32'h0000_0102; rdIn = 5'd10; inValid = 1'b1;
        @(negedge clk);
        checkOutput("misStallCapture", 32'(memStall), 32'd1);
        checkOutput("misNoReqCapture", 32'(dmemReq), 32'd0);
        @(posedge clk); #1;
        inValid = 1'b0;
        @(negedge clk);
        checkOutput("misErr", 32'(memErr), 32'd1);
        checkOutput("misNoReq", 32'(dmemReq), 32'd0);
        checkOutput("misStallDone", 32'(memStall), 32'd0);
`else
        expReq(32'h0000_0100, 4'b1111, 1'b0, 32'd0);
        expWb(5'd10, 32'h1357_9BDF);
        applyStimulus(L_TYPE, L_LW, 32'h0000_0102, 32'd0, 5'd10, 0, 0, 32'h1357_9BDF);
`endif

        expErr();
        @(posedge clk); #1;
        insnType = L_TYPE; insnSubType = L_LW; aluRes = 32'h0000_0300; rdIn = 5'd13; inValid = 1'b1;
        @(posedge clk); #1;
        inValid = 1'b0;
        dmemReady = 1'b0;
        reqCycles = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (dmemReq !== 1'b1) break;
            reqCycles++;
        end
        checkOutput("timeoutWaitCycles", 32'(reqCycles), 32'd4);
        checkOutput("timeoutErr", 32'(memErr), 32'd1);
        @(negedge clk);
        checkOutput("timeoutErrPulse", 32'(memErr), 32'd0);
        checkOutput("timeoutStall", 32'(memStall), 32'd0);

        expReq(32'h0000_0500, 4'b1111, 1'b0, 32'd0);
        @(posedge clk); #1;
        insnType = L_TYPE; insnSubType = L_LW; aluRes = 32'h0000_0500; rdIn = 5'd11; inValid = 1'b1;
        @(posedge clk); #1;
        inValid = 1'b0;
        dmemReady = 1'b1;
        @(posedge clk); #1;
        dmemReady = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        dmemRvalid = 1'b1; dmemRdata = 32'hFFFF_FFFF;
        @(negedge clk);
        checkOutput("midRstReq", 32'(dmemReq), 32'd0);
        checkOutput("midRstStall", 32'(memStall), 32'd0);
        checkOutput("midRstWbRd", 32'(wbRd), 32'd0);
        checkOutput("midRstWbVal", wbVal, 32'd0);
        checkOutput("midRstBpReg", 32'(bpReg), 32'd0);
        @(posedge clk); #1;
        dmemRvalid = 1'b0;
        @(negedge clk);
        checkOutput("midRstNoWb", 32'(wbWe), 32'd0);
        checkOutput("midRstStallAfter", 32'(memStall), 32'd0);

        repeat (2) @(negedge clk);
        checkOutput("scoreboardEmpty", 32'(sb.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
